obi_pattern_scan: RTL and testbench

Memory-scanning match accelerator for the user domain. It succeeds the single-pattern start/done/match accelerator with three additions: a full OBI register file, its own OBI manager port for fetching SRAM, and a parametrised bank of masked patterns with first-match and count-all modes. It is attached as a demux subordinate (register file) and drives the user manager port (data fetch); its interrupt feeds one `interrupts_o` line.

---
 rtl/obi_pattern_scan.sv | 200 ++++++++++++++++++++
 tb/tb_obi_pattern_scan.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_pattern_scan.sv
// Memory-scanning match accelerator: OBI register file plus an OBI read manager that
// fetches words from SRC_ADDR and matches each against a bank of masked patterns.
module obi_pattern_scan #(
  parameter int unsigned NumPatterns = 4,
  parameter int unsigned LenWidth    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Subordinate register port
  input  logic        obi_req_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_addr_i,
  input  logic [31:0] obi_wdata_i,
  input  logic [3:0]  obi_aid_i,
  output logic        obi_gnt_o,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic [3:0]  obi_rid_o,
  // Manager data-fetch port
  output logic        mgr_req_o,
  output logic        mgr_we_o,
  output logic [3:0]  mgr_be_o,
  output logic [31:0] mgr_addr_o,
  input  logic        mgr_gnt_i,
  input  logic        mgr_rvalid_i,
  input  logic [31:0] mgr_rdata_i,
  input  logic        mgr_err_i,
  output logic        irq_o,
  output logic [1:0]  state_o
);

  // Handshake: an address phase completes on a cycle with req & gnt; req/addr hold stable
  // until then. Exactly one response phase (rvalid, with rdata/err) follows each accepted request.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, irq_en_q, done_q, match_q, err_q, aborted_q;
  logic                  abort_pend_q, zero_pend_q;
  logic [31:0]           src_q, mask_q, match_addr_q, cur_addr_q;
  logic [LenWidth-1:0]   len_q, remaining_q, match_cnt_q;
  logic [NumPatterns-1:0] match_map_q, hit;
  logic [31:0]           pattern_q [NumPatterns];

  logic [5:0]  offset;
  logic [31:0] wmask, rdata_d;
  logic        wr, wr_ctrl, busy, start, abort_req, abort_now;
  logic        word_ok, word_err, finish, dec_err;
  logic        unused_addr_bits;

  assign offset           = obi_addr_i[7:2];
  assign unused_addr_bits = ^{obi_addr_i[31:8], obi_addr_i[1:0]};
  assign wmask     = {{8{obi_be_i[3]}}, {8{obi_be_i[2]}}, {8{obi_be_i[1]}}, {8{obi_be_i[0]}}};
  assign wr        = obi_req_i & obi_we_i;
  assign wr_ctrl   = wr & (offset == 6'd0) & obi_be_i[0];
  assign busy      = (state_q != IDLE) | zero_pend_q;
  assign start     = wr_ctrl & obi_wdata_i[0] & ~busy;
  assign abort_req = wr_ctrl & obi_wdata_i[3] & (state_q != IDLE);
  assign abort_now = abort_pend_q | abort_req;
  assign word_ok   = (state_q == WAIT) & mgr_rvalid_i & ~mgr_err_i;
  assign word_err  = (state_q == WAIT) & mgr_rvalid_i & mgr_err_i;
  assign finish    = word_ok & ((remaining_q == LenWidth'(1)) | (~mode_q & (|hit)) | abort_now);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < NumPatterns; i++)
      hit[i] = ((mgr_rdata_i ^ pattern_q[i]) & mask_q) == 32'h0;
  end

  always_comb begin
    rdata_d = '0;
    dec_err = 1'b0;
    case (offset)
      6'd0: rdata_d[2:1] = {irq_en_q, mode_q};
      6'd1: rdata_d[4:0] = {aborted_q, err_q, match_q, done_q, busy};
      6'd2: rdata_d = src_q;
      6'd3: rdata_d[LenWidth-1:0] = len_q;
      6'd4: rdata_d = mask_q;
      6'd5: rdata_d = match_addr_q;
      6'd6: rdata_d[LenWidth-1:0] = match_cnt_q;
      6'd7: rdata_d[NumPatterns-1:0] = match_map_q;
      default: begin
        dec_err = 1'b1;
        for (int i = 0; i < NumPatterns; i++) begin
          if (offset == 6'(8 + i)) begin
            dec_err = 1'b0;
            rdata_d = pattern_q[i];
          end
        end
      end
    endcase
    if (obi_we_i) rdata_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && len_q != '0) state_d = REQ;
      REQ:  if (mgr_gnt_i) state_d = WAIT;
      WAIT: begin
        if (word_err || finish) state_d = IDLE;
        else if (word_ok)       state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= 1'b0; irq_en_q <= 1'b0; done_q <= 1'b0; match_q <= 1'b0;
      err_q <= 1'b0; aborted_q <= 1'b0; abort_pend_q <= 1'b0; zero_pend_q <= 1'b0;
      src_q <= '0; mask_q <= '0; match_addr_q <= '0; cur_addr_q <= '0;
      len_q <= '0; remaining_q <= '0; match_cnt_q <= '0; match_map_q <= '0;
      for (int i = 0; i < NumPatterns; i++) pattern_q[i] <= '0;
    end else begin
      zero_pend_q <= start && (len_q == '0);
      if (wr && offset == 6'd1 && obi_be_i[0]) begin
        if (obi_wdata_i[1]) done_q    <= 1'b0;
        if (obi_wdata_i[2]) match_q   <= 1'b0;
        if (obi_wdata_i[3]) err_q     <= 1'b0;
        if (obi_wdata_i[4]) aborted_q <= 1'b0;
      end
      if (wr && !busy) begin
        case (offset)
          6'd0: if (obi_be_i[0]) begin
            mode_q   <= obi_wdata_i[1];
            irq_en_q <= obi_wdata_i[2];
          end
          6'd2: src_q  <= merge(src_q, obi_wdata_i, wmask) & 32'hFFFF_FFFC;
          6'd3: len_q  <= LenWidth'(merge(32'(len_q), obi_wdata_i, wmask));
          6'd4: mask_q <= merge(mask_q, obi_wdata_i, wmask);
          default: ;
        endcase
        for (int i = 0; i < NumPatterns; i++)
          if (offset == 6'(8 + i)) pattern_q[i] <= merge(pattern_q[i], obi_wdata_i, wmask);
      end
      if (abort_req) abort_pend_q <= 1'b1;
      if (start) begin
        done_q <= 1'b0; match_q <= 1'b0; err_q <= 1'b0; aborted_q <= 1'b0;
        match_addr_q <= '0; match_cnt_q <= '0; match_map_q <= '0;
        cur_addr_q <= src_q; remaining_q <= len_q; abort_pend_q <= 1'b0;
      end
      // Hardware status sets sit after the W1C so a coincident set wins.
      if (zero_pend_q) done_q <= 1'b1;
      if (word_err) begin
        err_q <= 1'b1; done_q <= 1'b1; abort_pend_q <= 1'b0;
      end
      if (word_ok) begin
        cur_addr_q  <= cur_addr_q + 32'd4;
        remaining_q <= remaining_q - LenWidth'(1);
        if (|hit) begin
          match_map_q <= match_map_q | hit;
          match_cnt_q <= match_cnt_q + LenWidth'(1);
          if (!match_q) begin
            match_addr_q <= cur_addr_q;
            match_q      <= 1'b1;
          end
        end
        if (finish) begin
          done_q       <= 1'b1;
          abort_pend_q <= 1'b0;
          if (abort_now) aborted_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obi_rvalid_o <= 1'b0; obi_rdata_o <= '0; obi_err_o <= 1'b0; obi_rid_o <= '0;
    end else begin
      obi_rvalid_o <= obi_req_i;
      if (obi_req_i) begin
        obi_rdata_o <= rdata_d;
        obi_err_o   <= dec_err;
        obi_rid_o   <= obi_aid_i;
      end
    end
  end

  assign obi_gnt_o  = 1'b1;
  assign mgr_req_o  = (state_q == REQ);
  assign mgr_addr_o = cur_addr_q;
  assign mgr_we_o   = 1'b0;
  assign mgr_be_o   = 4'hF;
  assign irq_o      = done_q & irq_en_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_obi_pattern_scan.sv
// Self-checking bench for obi_pattern_scan: directed scenarios plus randomized scans
// compared against a word-by-word behavioural model.
module tb_obi_pattern_scan;
  localparam int NP = 4;
  localparam int LW = 16;
  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_SRC = 32'h08, A_LEN = 32'h0C;
  localparam logic [31:0] A_MASK = 32'h10, A_MADDR = 32'h14, A_MCNT = 32'h18, A_MMAP = 32'h1C;
  localparam logic [31:0] A_PAT = 32'h20;

  logic clk, rst_ni;
  logic obi_req_i, obi_we_i, obi_gnt_o, obi_rvalid_o, obi_err_o;
  logic [3:0] obi_be_i, obi_aid_i, obi_rid_o, mgr_be_o;
  logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o, mgr_addr_o, mgr_rdata_i;
  logic mgr_req_o, mgr_we_o, mgr_gnt_i, mgr_rvalid_i, mgr_err_i, irq_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [bit [31:0]];
  logic [31:0] err_list[$];
  logic [31:0] fetch_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pat [NP];
  logic [3:0]  last_aid;
  int req_cycles = 0;
  int force_stall = -1;

  obi_pattern_scan #(.NumPatterns(NP), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_addr_i(obi_addr_i),
    .obi_wdata_i(obi_wdata_i), .obi_aid_i(obi_aid_i), .obi_gnt_o(obi_gnt_o),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .obi_rid_o(obi_rid_o), .mgr_req_o(mgr_req_o), .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o),
    .mgr_addr_o(mgr_addr_o), .mgr_gnt_i(mgr_gnt_i), .mgr_rvalid_i(mgr_rvalid_i),
    .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i), .irq_o(irq_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_err(input logic [31:0] a);
    foreach (err_list[i]) if (err_list[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // SRAM-side responder: random grant stalls, response one cycle after the grant
  initial begin
    bit prev_gnt, in_req;
    logic [31:0] prev_addr;
    int stall;
    prev_gnt = 0; in_req = 0; stall = 0; prev_addr = '0;
    mgr_gnt_i = 0; mgr_rvalid_i = 0; mgr_rdata_i = '0; mgr_err_i = 0;
    forever begin
      @(posedge clk); #1;
      mgr_rvalid_i = 0; mgr_err_i = 0; mgr_rdata_i = $urandom;
      if (!rst_ni) begin
        prev_gnt = 0; in_req = 0; mgr_gnt_i = 0;
      end else begin
        if (prev_gnt) begin
          fetch_q.push_back(prev_addr);
          mgr_rvalid_i = 1;
          mgr_err_i    = is_err(prev_addr);
          if (!mgr_err_i) mgr_rdata_i = mem_rd(prev_addr);
          in_req = 0;
        end
        mgr_gnt_i = 0;
        if (mgr_req_o) begin
          req_cycles++;
          if (!in_req) begin
            in_req = 1;
            stall  = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
          end
          if (stall == 0) mgr_gnt_i = 1;
          else stall--;
        end
        prev_gnt  = mgr_gnt_i;
        prev_addr = mgr_addr_o;
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    obi_req_i = 1; obi_we_i = 1; obi_be_i = 4'hF; obi_addr_i = addr; obi_wdata_i = data;
    obi_aid_i = 4'($urandom_range(0, 15)); last_aid = obi_aid_i;
    @(posedge clk); #1;
    obi_req_i = 0; obi_we_i = 0;
    err = obi_err_o;
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    obi_req_i = 1; obi_we_i = 0; obi_be_i = 4'hF; obi_addr_i = addr; obi_wdata_i = $urandom;
    obi_aid_i = 4'($urandom_range(0, 15)); last_aid = obi_aid_i;
    @(posedge clk); #1;
    obi_req_i = 0;
    data = obi_rdata_o; err = obi_err_o;
  endtask

  task automatic write_patterns();
    logic e;
    for (int i = 0; i < NP; i++) reg_write(A_PAT + 32'(i * 4), pat[i], e);
  endtask

  task automatic run_scan(input logic [31:0] src, input logic [15:0] len, input bit mode,
                          input bit irq_en, input logic [31:0] mask, output logic [31:0] st,
                          output logic [31:0] ma, output logic [31:0] mc, output logic [31:0] mm,
                          output bit timeout);
    logic e;
    logic [31:0] d;
    reg_write(A_SRC, src, e);
    reg_write(A_LEN, 32'(len), e);
    reg_write(A_MASK, mask, e);
    fetch_q.delete();
    reg_write(A_CTRL, {29'b0, irq_en, mode, 1'b1}, e);
    timeout = 1; d = '0;
    for (int k = 0; k < 400; k++) begin
      reg_read(A_STATUS, d, e);
      if (d[1]) begin timeout = 0; break; end
    end
    st = d;
    reg_read(A_MADDR, ma, e);
    reg_read(A_MCNT, mc, e);
    reg_read(A_MMAP, mm, e);
  endtask

  // reference model: walk the words in order and apply the match rules directly
  task automatic model_scan(input logic [31:0] src, input int len, input bit mode,
                            input logic [31:0] mask, output bit e_match, output logic [31:0] e_addr,
                            output int e_cnt, output logic [NP-1:0] e_map, output bit e_err);
    logic [31:0] a, w;
    logic [NP-1:0] h;
    exp_q.delete();
    e_match = 0; e_addr = '0; e_cnt = 0; e_map = '0; e_err = 0;
    for (int k = 0; k < len; k++) begin
      a = src + 32'(k) * 32'd4;
      exp_q.push_back(a);
      if (is_err(a)) begin e_err = 1; break; end
      w = mem_rd(a);
      h = '0;
      for (int i = 0; i < NP; i++) h[i] = (((w ^ pat[i]) & mask) == 32'h0);
      if (h != '0) begin
        e_map |= h; e_cnt++;
        if (!e_match) begin e_match = 1; e_addr = a; end
        if (!mode) break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    checks++; if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%b exp=1", obi_gnt_o); end
    checks++; if (obi_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", obi_rvalid_o); end
    checks++; if ({mgr_req_o, mgr_addr_o} !== 33'h0) begin errors++; $display("FAIL reset_mgr got=%b/%h exp=0/0", mgr_req_o, mgr_addr_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    for (int r = 0; r < 8 + NP; r++) begin
      reg_read(32'(r * 4), d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        errors++; $display("FAIL reset_reg off=%h got=%h/%b exp=0/0", r * 4, d, e);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic e;
    reg_write(A_SRC, 32'h1234_5677, e);
    reg_read(A_SRC, d, e);
    checks++; if (d !== 32'h1234_5674) begin errors++; $display("FAIL src_align got=%h exp=12345674", d); end
    checks++; if (obi_rid_o !== last_aid) begin errors++; $display("FAIL rid_echo got=%h exp=%h", obi_rid_o, last_aid); end
    reg_write(A_CTRL, 32'h0000_000E, e);
    reg_read(A_CTRL, d, e);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ctrl_rd got=%h exp=6", d); end
    reg_write(A_CTRL, 32'h0, e);
    reg_read(32'h3C, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL unmapped_rd got=%h/%b exp=0/1", d, e); end
    reg_write(32'h3C, 32'hDEAD_BEEF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmapped_wr err got=%b exp=1", e); end
    reg_write(A_PAT + 32'h4, 32'hA5A5_0001, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL pat_wr err got=%b exp=0", e); end
    reg_read(A_PAT + 32'h4, d, e);
    checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL pat_rd got=%h exp=a5a50001", d); end
  endtask

  task automatic test_first_match();
    logic [31:0] st, ma, mc, mm;
    bit to;
    mem[32'h1000_0000] = 32'h1; mem[32'h1000_0004] = 32'h2;
    mem[32'h1000_0008] = 32'hCAFE; mem[32'h1000_000C] = 32'hCAFE;
    pat[0] = 32'hCAFE; pat[1] = 32'h1111_1111; pat[2] = 32'h2222_2222; pat[3] = 32'h3333_3333;
    write_patterns();
    run_scan(32'h1000_0000, 16'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, st, ma, mc, mm, to);
    repeat (10) @(posedge clk); #1;
    checks++; if (to) begin errors++; $display("FAIL first_match timeout got=1 exp=0"); end
    checks++; if (fetch_q.size() != 3) begin errors++; $display("FAIL first_match fetches got=%0d exp=3", fetch_q.size()); end
    checks++; if (ma !== 32'h1000_0008) begin errors++; $display("FAIL first_match addr got=%h exp=10000008", ma); end
    checks++; if (mc !== 32'h1 || mm !== 32'h1) begin errors++; $display("FAIL first_match cnt/map got=%h/%h exp=1/1", mc, mm); end
    checks++; if (st[4:0] !== 5'b00110) begin errors++; $display("FAIL first_match status got=%b exp=00110", st[4:0]); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL first_match irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_count_all();
    logic [31:0] st, ma, mc, mm;
    bit to;
    pat[0] = 32'h55; pat[1] = 32'h02; pat[2] = 32'h55; pat[3] = 32'h55;
    write_patterns();
    run_scan(32'h1000_0000, 16'd4, 1'b1, 1'b0, 32'h0000_00FF, st, ma, mc, mm, to);
    checks++; if (to) begin errors++; $display("FAIL count_all timeout got=1 exp=0"); end
    checks++; if (fetch_q.size() != 4) begin errors++; $display("FAIL count_all fetches got=%0d exp=4", fetch_q.size()); end
    checks++; if (mc !== 32'h1 || mm !== 32'h2) begin errors++; $display("FAIL count_all cnt/map got=%h/%h exp=1/2", mc, mm); end
    checks++; if (ma !== 32'h1000_0004) begin errors++; $display("FAIL count_all addr got=%h exp=10000004", ma); end
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    logic e;
    reg_write(A_LEN, 32'h0, e);
    req_cycles = 0;
    reg_write(A_CTRL, 32'h5, e);
    @(posedge clk); #1;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL len0 irq got=%b exp=1", irq_o); end
    reg_read(A_STATUS, d, e);
    checks++; if (d[1:0] !== 2'b10) begin errors++; $display("FAIL len0 status got=%b exp=10", d[1:0]); end
    checks++; if (req_cycles != 0) begin errors++; $display("FAIL len0 req_cycles got=%0d exp=0", req_cycles); end
    reg_write(A_STATUS, 32'h2, e);
    reg_read(A_STATUS, d, e);
    checks++; if (d[1] !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL len0 clear got=%b/%b exp=0/0", d[1], irq_o); end
    reg_write(A_CTRL, 32'h0, e);
  endtask

  task automatic test_bus_error();
    logic [31:0] st, ma, mc, mm;
    bit to;
    pat[0] = 32'h1; pat[1] = 32'h77; pat[2] = 32'h77; pat[3] = 32'h77;
    write_patterns();
    err_list.push_back(32'h1000_0004);
    run_scan(32'h1000_0000, 16'd4, 1'b1, 1'b0, 32'hFFFF_FFFF, st, ma, mc, mm, to);
    repeat (10) @(posedge clk); #1;
    err_list.delete();
    checks++; if (to) begin errors++; $display("FAIL bus_err timeout got=1 exp=0"); end
    checks++; if (st[3] !== 1'b1 || st[1] !== 1'b1) begin errors++; $display("FAIL bus_err status got=%b exp=x1x1x", st[4:0]); end
    checks++; if (fetch_q.size() != 2) begin errors++; $display("FAIL bus_err fetches got=%0d exp=2", fetch_q.size()); end
    checks++; if (mc !== 32'h1) begin errors++; $display("FAIL bus_err cnt got=%h exp=1", mc); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic e;
    bit done;
    pat[0] = 32'h77; pat[1] = 32'h77; pat[2] = 32'h77; pat[3] = 32'h77;
    write_patterns();
    reg_write(A_SRC, 32'h1000_0000, e);
    reg_write(A_LEN, 32'd4, e);
    force_stall = 5;
    fetch_q.delete();
    reg_write(A_CTRL, 32'h3, e);
    checks++; if (mgr_req_o !== 1'b1 || mgr_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL abort req0 got=%b/%h exp=1/10000000", mgr_req_o, mgr_addr_o); end
    reg_write(A_CTRL, 32'h8, e);
    checks++; if (mgr_req_o !== 1'b1 || mgr_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL abort req1 got=%b/%h exp=1/10000000", mgr_req_o, mgr_addr_o); end
    reg_write(A_CTRL, 32'h1, e);
    checks++; if (mgr_req_o !== 1'b1 || mgr_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL abort req2 got=%b/%h exp=1/10000000", mgr_req_o, mgr_addr_o); end
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      reg_read(A_STATUS, d, e);
      done = d[1];
    end
    force_stall = -1;
    repeat (10) @(posedge clk); #1;
    checks++; if (!done) begin errors++; $display("FAIL abort timeout got=0 exp=1"); end
    checks++; if (d[4] !== 1'b1) begin errors++; $display("FAIL abort aborted got=%b exp=1", d[4]); end
    checks++; if (fetch_q.size() != 1) begin errors++; $display("FAIL abort fetches got=%0d exp=1", fetch_q.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] st, ma, mc, mm;
    bit to;
    run_scan(32'hFFFF_FFFC, 16'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, st, ma, mc, mm, to);
    checks++;
    if (to || fetch_q.size() != 2) begin
      errors++; $display("FAIL wrap fetches got=%0d exp=2", fetch_q.size());
    end else if (fetch_q[0] !== 32'hFFFF_FFFC || fetch_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap addrs got=%h,%h exp=fffffffc,00000000", fetch_q[0], fetch_q[1]);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] d;
    logic e;
    reg_write(A_SRC, 32'h1000_0000, e);
    reg_write(A_LEN, 32'd4, e);
    force_stall = 10;
    reg_write(A_CTRL, 32'h3, e);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (mgr_req_o !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL async_rst got=%b/%0d exp=0/0", mgr_req_o, state_o); end
    force_stall = -1;
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    reg_read(A_SRC, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_rst src got=%h exp=0", d); end
    // patterns were cleared by reset
    for (int i = 0; i < NP; i++) pat[i] = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] st, ma, mc, mm, src, mask;
    logic [31:0] ws [4];
    logic [31:0] masks [4];
    bit to, mode, e_match, e_err;
    logic [31:0] e_addr;
    int e_cnt, len;
    logic [NP-1:0] e_map;
    masks[0] = 32'hFFFF_FFFF; masks[1] = 32'h0000_00FF; masks[2] = 32'hFFFF_0000; masks[3] = 32'h0F0F_0F0F;
    for (int it = 0; it < 24; it++) begin
      for (int j = 0; j < 4; j++) ws[j] = $urandom;
      src  = 32'h2000_0000 + 32'($urandom_range(0, 63)) * 4;
      len  = $urandom_range(1, 8);
      mode = 1'($urandom_range(0, 1));
      mask = masks[$urandom_range(0, 3)];
      for (int k = 0; k < len; k++)
        mem[src + 32'(k * 4)] = ($urandom_range(0, 2) != 0) ? ws[$urandom_range(0, 3)] : $urandom;
      for (int i = 0; i < NP; i++) pat[i] = ($urandom_range(0, 1) != 0) ? ws[$urandom_range(0, 3)] : $urandom;
      err_list.delete();
      if ($urandom_range(0, 4) == 0) err_list.push_back(src + 32'($urandom_range(0, len - 1) * 4));
      write_patterns();
      run_scan(src, 16'(len), mode, 1'b1, mask, st, ma, mc, mm, to);
      model_scan(src, len, mode, mask, e_match, e_addr, e_cnt, e_map, e_err);
      checks++;
      if (to || fetch_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d fetches got=%0d exp=%0d", it, fetch_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) if (fetch_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rnd%0d fetch_addr[%0d] got=%h exp=%h", it, k, fetch_q[k], exp_q[k]);
          break;
        end
      end
      checks++; if (st[4:0] !== {1'b0, e_err, e_match, 1'b1, 1'b0}) begin errors++; $display("FAIL rnd%0d status got=%b exp=%b", it, st[4:0], {1'b0, e_err, e_match, 1'b1, 1'b0}); end
      checks++; if (ma !== e_addr || mc !== 32'(e_cnt) || mm !== 32'(e_map)) begin errors++; $display("FAIL rnd%0d match got=%h/%h/%h exp=%h/%h/%h", it, ma, mc, mm, e_addr, e_cnt, e_map); end
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL rnd%0d irq got=%b exp=1", it, irq_o); end
    end
    err_list.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    obi_req_i = 0; obi_we_i = 0; obi_be_i = 4'h0; obi_addr_i = '0; obi_wdata_i = '0; obi_aid_i = '0;
    last_aid = '0;
    for (int i = 0; i < NP; i++) pat[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_regs();
    test_first_match();
    test_count_all();
    test_len_zero();
    test_bus_error();
    test_abort();
    test_wrap();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
